// File: rtl/sample_framer.sv
// sample_framer: drops SKIP_LEN ce-qualified samples after a chirp, then frames FRAME_LEN pairs.
// Latency: a captured pair appears on data_*_o one clock after capture when the buffer is empty.
// Backpressure: valid_o/ready_i handshake; pairs arriving with a full buffer and no pop are dropped (sticky overflow_o).
//
// Ports:
//   clk_i, rst_i          : clock and synchronous active-high reset
//   ce_i                  : sample-valid qualifier for chan_a_i/chan_b_i
//   chan_a_i, chan_b_i    : signed ADC channel samples
//   chirp_start_i         : single-cycle ramp-start pulse
//   data_a_o, data_b_o    : framed sample pair (zero when valid_o is low)
//   valid_o, ready_i      : output handshake
//   last_o                : final pair of a frame
//   busy_o                : capture sequencer is not idle
//   overflow_o            : sticky, a pair was dropped
//   frame_cnt_o           : completed-frame counter (wraps)
module sample_framer #(
  parameter int DATA_WIDTH = 12,
  parameter int SKIP_LEN   = 16,
  parameter int FRAME_LEN  = 2048,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ce_i,
  input  logic signed [DATA_WIDTH-1:0] chan_a_i,
  input  logic signed [DATA_WIDTH-1:0] chan_b_i,
  input  logic                         chirp_start_i,
  output logic signed [DATA_WIDTH-1:0] data_a_o,
  output logic signed [DATA_WIDTH-1:0] data_b_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         last_o,
  output logic                         busy_o,
  output logic                         overflow_o,
  output logic [15:0]                  frame_cnt_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 2 * DATA_WIDTH + 1;

  localparam logic [15:0] SKIP_LAST  = 16'(SKIP_LEN - 1);
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_LEN - 1);
  localparam logic [AW:0] DEPTH_C    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_CAPTURE
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;        // skip count in S_SKIP, sample index in S_CAPTURE
  logic [15:0] r_frame_cnt;

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic          w_last;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_valid;
  logic [EW-1:0] w_head;

  assign w_last     = (r_cnt == FRAME_LAST);
  assign w_push_req = (r_state == S_CAPTURE) && ce_i;
  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == DEPTH_C);
  assign w_pop      = w_valid && ready_i;
  // A full buffer still takes a pair when the head leaves on the same edge.
  assign w_push     = w_push_req && (!w_full || w_pop);

  // Capture sequencer. The chirp cycle itself never contributes a sample,
  // and a chirp seen while not idle (including the final-sample cycle) is ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (chirp_start_i) begin
            r_cnt <= '0;
            if (SKIP_LEN == 0) begin
              r_state <= S_CAPTURE;
            end else begin
              r_state <= S_SKIP;
            end
          end
        end
        S_SKIP: begin
          if (ce_i) begin
            if (r_cnt == SKIP_LAST) begin
              r_cnt   <= '0;
              r_state <= S_CAPTURE;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        S_CAPTURE: begin
          if (ce_i) begin
            if (w_last) begin
              r_cnt       <= '0;
              r_state     <= S_IDLE;
              r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Storage needs no reset: everything read out is gated by occupancy.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_last, chan_a_i, chan_b_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign valid_o     = w_valid;
  assign data_a_o    = w_valid ? $signed(w_head[2*DATA_WIDTH-1:DATA_WIDTH]) : '0;
  assign data_b_o    = w_valid ? $signed(w_head[DATA_WIDTH-1:0]) : '0;
  assign last_o      = w_valid && w_head[EW-1];
  assign busy_o      = (r_state != S_IDLE);
  assign overflow_o  = r_overflow;
  assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_sample_framer.sv
module tb_sample_framer;

  localparam int DW    = 12;
  localparam int SKIP  = 2;
  localparam int FRAME = 4;

  typedef logic [2*DW:0] pair_t;  // {last, a, b}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 ce;
  logic                 chirp;
  logic                 ready;
  logic signed [DW-1:0] chan_a;
  logic signed [DW-1:0] chan_b;

  logic signed [DW-1:0] a0, b0, a1, b1;
  logic                 v0, l0, busy0, ovf0;
  logic                 v1, l1, busy1, ovf1;
  logic [15:0]          fc0, fc1;

  sample_framer #(.DATA_WIDTH(DW), .SKIP_LEN(SKIP), .FRAME_LEN(FRAME), .FIFO_DEPTH(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .chan_a_i(chan_a), .chan_b_i(chan_b),
    .chirp_start_i(chirp), .data_a_o(a0), .data_b_o(b0), .valid_o(v0), .ready_i(ready),
    .last_o(l0), .busy_o(busy0), .overflow_o(ovf0), .frame_cnt_o(fc0)
  );

  sample_framer #(.DATA_WIDTH(DW), .SKIP_LEN(SKIP), .FRAME_LEN(FRAME), .FIFO_DEPTH(2)) u_dut_small (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .chan_a_i(chan_a), .chan_b_i(chan_b),
    .chirp_start_i(chirp), .data_a_o(a1), .data_b_o(b1), .valid_o(v1), .ready_i(ready),
    .last_o(l1), .busy_o(busy1), .overflow_o(ovf1), .frame_cnt_o(fc1)
  );

  int    total = 0;
  int    bad   = 0;
  pair_t q0[$];
  pair_t q1[$];
  int    pop_steps[$];
  int    step_no = 0;
  bit    m_active;
  int    m_idx;
  int    m_frames;
  bit    mon1;
  bit    prev_stall0;
  pair_t prev_dat0;

  // One clock of stimulus plus scoreboard checking at the falling edge.
  task automatic step(input bit c_chirp, input bit c_ce, input bit c_rdy, input int val);
    logic signed [DW-1:0] va, vb;
    pair_t want, got;
    va     = DW'(val);
    vb     = ~va;
    chirp  = c_chirp;
    ce     = c_ce;
    ready  = c_rdy;
    chan_a = va;
    chan_b = vb;
    if (!m_active) begin
      if (c_chirp) begin
        m_active = 1'b1;
        m_idx    = 0;
      end
    end else if (c_ce) begin
      if (m_idx >= SKIP) begin
        want = {(m_idx == SKIP + FRAME - 1) ? 1'b1 : 1'b0, va, vb};
        q0.push_back(want);
      end
      m_idx++;
      if (m_idx == SKIP + FRAME) begin
        m_active = 1'b0;
        m_frames++;
      end
    end
    @(negedge clk);
    got = {l0, a0, b0};
    if (prev_stall0) begin
      total++;
      if (v0 !== 1'b1 || got !== prev_dat0) begin
        bad++;
        $display("FAIL hold_stable step=%0d: valid=%b pair=%h, required valid=1 pair=%h", step_no, v0, got, prev_dat0);
      end
    end
    if (v0 !== 1'b1) begin
      total++;
      if (got !== '0) begin
        bad++;
        $display("FAIL idle_zero step=%0d: pair=%h, required 0", step_no, got);
      end
    end
    if (v0 === 1'b1 && ready === 1'b1) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pair step=%0d: got %h, required no output", step_no, got);
      end else begin
        want = q0.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL pair step=%0d: got %h, required %h", step_no, got, want);
        end
      end
      pop_steps.push_back(step_no);
    end
    prev_stall0 = (v0 === 1'b1) && (ready !== 1'b1);
    prev_dat0   = got;
    if (mon1 && v1 === 1'b1 && ready === 1'b1) begin
      got = {l1, a1, b1};
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL small_unexpected step=%0d: got %h, required no output", step_no, got);
      end else begin
        want = q1.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL small_pair step=%0d: got %h, required %h", step_no, got, want);
        end
      end
    end
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    chirp = 1'b0;
    ce    = 1'b0;
    ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    pop_steps.delete();
    m_active    = 1'b0;
    m_idx       = 0;
    m_frames    = 0;
    mon1        = 1'b0;
    prev_stall0 = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    chan_a = '0;
    chan_b = '0;
    apply_reset();
    @(negedge clk);
    total++; if (v0 !== 1'b0)      begin bad++; $display("FAIL rst_valid: %b, required 0", v0); end
    total++; if (l0 !== 1'b0)      begin bad++; $display("FAIL rst_last: %b, required 0", l0); end
    total++; if (busy0 !== 1'b0)   begin bad++; $display("FAIL rst_busy: %b, required 0", busy0); end
    total++; if (ovf0 !== 1'b0)    begin bad++; $display("FAIL rst_overflow: %b, required 0", ovf0); end
    total++; if (fc0 !== 16'd0)    begin bad++; $display("FAIL rst_frame_cnt: %0d, required 0", fc0); end
    total++; if (a0 !== '0 || b0 !== '0) begin bad++; $display("FAIL rst_data: a=%0d b=%0d, required 0", a0, b0); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int base;
    apply_reset();
    base = step_no;
    step(1, 1, 1, 0);
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL basic_busy_skip: %b, required 1", busy0); end
    for (int i = 1; i <= 8; i++) step(0, 1, 1, i);
    total++; if (pop_steps.size() != 4) begin bad++; $display("FAIL basic_count: %0d pairs, required 4", pop_steps.size()); end
    for (int i = 0; i < pop_steps.size() && i < 4; i++) begin
      total++;
      if (pop_steps[i] != base + 4 + i) begin
        bad++;
        $display("FAIL basic_timing pair %0d: step %0d, required %0d", i, pop_steps[i] - base, 4 + i);
      end
    end
    total++; if (q0.size() != 0) begin bad++; $display("FAIL basic_missing: %0d pending, required 0", q0.size()); end
    total++; if (fc0 !== 16'(m_frames)) begin bad++; $display("FAIL basic_frame_cnt: %0d, required %0d", fc0, m_frames); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL basic_busy_after: %b, required 0", busy0); end
  endtask

  task automatic test_ce_gaps();
    int base;
    int val;
    apply_reset();
    base = step_no;
    val  = 1;
    step(1, 1, 1, 0);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        step(0, 1, 1, val);
        val++;
      end else begin
        step(0, 0, 1, 2047);
      end
    end
    total++; if (pop_steps.size() != 4) begin bad++; $display("FAIL gaps_count: %0d pairs, required 4", pop_steps.size()); end
    if (pop_steps.size() == 4) begin
      total++; if (pop_steps[0] != base + 6) begin bad++; $display("FAIL gaps_first: step %0d, required 6", pop_steps[0] - base); end
      for (int i = 0; i < 3; i++) begin
        total++;
        if (pop_steps[i+1] - pop_steps[i] != 2) begin
          bad++;
          $display("FAIL gaps_spacing %0d: %0d cycles, required 2", i, pop_steps[i+1] - pop_steps[i]);
        end
      end
    end
    total++; if (fc0 !== 16'(m_frames)) begin bad++; $display("FAIL gaps_frame_cnt: %0d, required %0d", fc0, m_frames); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    step(1, 1, 0, 0);
    for (int i = 1; i <= 6; i++) step(0, 1, 0, i);
    total++; if (v0 !== 1'b1) begin bad++; $display("FAIL bp_valid_stalled: %b, required 1", v0); end
    total++; if (q0.size() != 4) begin bad++; $display("FAIL bp_model_depth: %0d, required 4", q0.size()); end
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    total++; if (pop_steps.size() != 4) begin bad++; $display("FAIL bp_count: %0d pairs, required 4", pop_steps.size()); end
    total++; if (q0.size() != 0) begin bad++; $display("FAIL bp_missing: %0d pending, required 0", q0.size()); end
    total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL bp_overflow: %b, required 0", ovf0); end
  endtask

  task automatic test_overflow();
    apply_reset();
    step(1, 1, 0, 0);
    for (int i = 1; i <= 6; i++) step(0, 1, 0, i);
    total++; if (ovf1 !== 1'b1) begin bad++; $display("FAIL ovf_set: %b, required 1", ovf1); end
    total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL ovf_deep_fifo: %b, required 0", ovf0); end
    if (q0.size() >= 2) begin
      q1.push_back(q0[0]);
      q1.push_back(q0[1]);
    end
    mon1 = 1'b1;
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    total++; if (q1.size() != 0) begin bad++; $display("FAIL ovf_missing: %0d pending, required 0", q1.size()); end
    total++; if (v1 !== 1'b0) begin bad++; $display("FAIL ovf_drained: valid=%b, required 0", v1); end
    total++; if (ovf1 !== 1'b1) begin bad++; $display("FAIL ovf_sticky: %b, required 1", ovf1); end
    total++; if (fc1 !== 16'd1) begin bad++; $display("FAIL ovf_frame_cnt: %0d, required 1", fc1); end
  endtask

  task automatic test_retrigger();
    apply_reset();
    step(1, 1, 1, 0);
    step(0, 1, 1, 1);
    step(1, 1, 1, 2);
    step(0, 1, 1, 3);
    step(1, 1, 1, 4);
    step(0, 1, 1, 5);
    step(0, 1, 1, 6);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 7 + i);
    total++; if (pop_steps.size() != 4) begin bad++; $display("FAIL retrig_count: %0d pairs, required 4", pop_steps.size()); end
    total++; if (fc0 !== 16'd1) begin bad++; $display("FAIL retrig_frame_cnt: %0d, required 1", fc0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL retrig_busy: %b, required 0", busy0); end
  endtask

  task automatic test_back_to_back();
    int base;
    apply_reset();
    base = step_no;
    step(1, 1, 1, 0);
    for (int i = 1; i <= 5; i++) step(0, 1, 1, i);
    step(1, 1, 1, 6);   // chirp on the final-sample cycle must be ignored
    step(0, 1, 1, 7);
    step(1, 1, 1, 0);
    for (int i = 11; i <= 16; i++) step(0, 1, 1, i);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    total++; if (pop_steps.size() != 8) begin bad++; $display("FAIL b2b_count: %0d pairs, required 8", pop_steps.size()); end
    if (pop_steps.size() == 8) begin
      total++; if (pop_steps[4] != base + 12) begin bad++; $display("FAIL b2b_second_start: step %0d, required 12", pop_steps[4] - base); end
    end
    total++; if (fc0 !== 16'd2) begin bad++; $display("FAIL b2b_frame_cnt: %0d, required 2", fc0); end
    total++; if (q0.size() != 0) begin bad++; $display("FAIL b2b_missing: %0d pending, required 0", q0.size()); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    step(1, 1, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, 0, i);
    total++; if (v0 !== 1'b1) begin bad++; $display("FAIL mid_prefill: valid=%b, required 1", v0); end
    ce = 1'b1;
    apply_reset();
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL mid_valid: %b, required 0", v0); end
    total++; if (fc0 !== 16'd0) begin bad++; $display("FAIL mid_frame_cnt: %0d, required 0", fc0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL mid_busy: %b, required 0", busy0); end
    for (int i = 0; i < 3; i++) step(0, 1, 1, 50 + i);
    step(1, 1, 1, 0);
    for (int i = 1; i <= 8; i++) step(0, 1, 1, 100 + i);
    total++; if (pop_steps.size() != 4) begin bad++; $display("FAIL mid_clean_count: %0d pairs, required 4", pop_steps.size()); end
    total++; if (fc0 !== 16'd1) begin bad++; $display("FAIL mid_clean_frame_cnt: %0d, required 1", fc0); end
    total++; if (q0.size() != 0) begin bad++; $display("FAIL mid_missing: %0d pending, required 0", q0.size()); end
  endtask

  initial begin
    rst    = 1'b1;
    ce     = 1'b0;
    chirp  = 1'b0;
    ready  = 1'b0;
    chan_a = '0;
    chan_b = '0;
    test_reset();
    test_basic();
    test_ce_gaps();
    test_backpressure();
    test_overflow();
    test_retrigger();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: width of each ADC channel sample.
REQ-002 SHALL have parameter SKIP_LEN, default 16: samples discarded after chirp start (PLL settling); range 0 to 65535.
REQ-003 SHALL have parameter FRAME_LEN, default 2048: samples captured per chirp; range 2 to 65535.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: output buffer entries; power of two, at least 2.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port ce_i, input, 1 bit: ADC sample-valid qualifier; chan_a_i/chan_b_i are sampled only when high.
REQ-008 SHALL have ports chan_a_i and chan_b_i, input, DATA_WIDTH bits each, signed: channel samples, stable at the rising edge.
REQ-009 SHALL have port chirp_start_i, input, 1 bit: single-cycle pulse marking the start of a ramp.
REQ-010 SHALL have ports data_a_o and data_b_o, output, DATA_WIDTH bits each, signed: framed sample pair.
REQ-011 SHALL have port valid_o, output, 1 bit: output pair valid.
REQ-012 SHALL have port ready_i, input, 1 bit: consumer accepts the pair.
REQ-013 SHALL have port last_o, output, 1 bit: marks the final pair of a frame.
REQ-014 SHALL have port busy_o, output, 1 bit: FSM is not IDLE.
REQ-015 SHALL have port overflow_o, output, 1 bit: sticky flag set when a sample is dropped.
REQ-016 SHALL have port frame_cnt_o, output, 16 bits: count of completed frames.

Function
REQ-017 SHALL implement FSM states IDLE, SKIP and CAPTURE.
REQ-018 SHALL move IDLE->SKIP on chirp_start_i, or IDLE->CAPTURE when SKIP_LEN=0.
REQ-019 SHALL, in SKIP, count ce_i-qualified samples, discard them, and enter CAPTURE after SKIP_LEN of them.
REQ-020 SHALL, in CAPTURE, push each ce_i-qualified pair into the FIFO with tag last = (sample index == FRAME_LEN-1).
REQ-021 SHALL return to IDLE on the cycle the FRAME_LEN-th sample is taken, and increment frame_cnt_o by 1 at that cycle, wrapping 0xFFFF->0.
REQ-022 SHALL ignore chirp_start_i while in SKIP or CAPTURE.
REQ-023 SHALL honour chirp_start_i arriving on the same cycle as the IDLE return only from the next cycle onward.
REQ-024 SHALL NOT take a sample on the cycle chirp_start_i is accepted.
REQ-025 SHALL NOT advance any counter on a cycle with ce_i low.
REQ-026 SHALL transfer an output pair when valid_o and ready_i are both high; the FIFO pops on that cycle.
REQ-027 SHALL hold data_a_o, data_b_o and last_o stable while valid_o is high and ready_i is low.
REQ-028 SHALL present a pushed pair on the outputs, with valid_o high, the cycle after the push when the FIFO was empty (latency 1).
REQ-029 SHALL accept a push when the FIFO is full only if a pop occurs on the same cycle.
REQ-030 SHALL otherwise drop the pair and set overflow_o; the sample count still advances, and last_o may be lost.
REQ-031 SHALL accept simultaneous push and pop with no change in FIFO occupancy.
REQ-032 SHALL pass data through unmodified, with no width change.
REQ-033 SHALL hold data_a_o and data_b_o at zero when valid_o is low.

Reset
REQ-034 SHALL, on rst_i high at a rising edge, enter IDLE and empty the FIFO.
REQ-035 SHALL, on reset, set valid_o=0, last_o=0, busy_o=0, overflow_o=0, frame_cnt_o=0, data_a_o=0 and data_b_o=0.
REQ-036 SHALL abort a frame on reset mid-frame, discarding any partial frame and buffered pairs.
REQ-037 SHALL clear overflow_o only by reset.

Verification (SKIP_LEN=2, FRAME_LEN=4, FIFO_DEPTH=4)
REQ-038 SHALL cover basic frame: ready_i=1, ce_i=1, chan_a_i counting 1,2,3..., chirp pulse at cycle 0 -> samples 1,2 discarded; pairs 3,4,5,6 out on consecutive cycles; last_o with 6; frame_cnt_o=1; busy_o low after.
REQ-039 SHALL cover ce_i gaps: ce_i toggles 1,0 each cycle -> same four pairs as REQ-038, spaced two cycles apart, no duplicates.
REQ-040 SHALL cover backpressure: ready_i=0 through capture, then 1 -> four pairs held in order; output stable while stalled; overflow_o=0.
REQ-041 SHALL cover overflow: FIFO_DEPTH=2, ready_i=0 -> first two pairs retained, remaining two dropped, overflow_o=1 and stays 1 after draining.
REQ-042 SHALL cover ignored re-trigger: chirp pulse repeated during CAPTURE -> frame completes normally, exactly one frame, frame_cnt_o=1.
REQ-043 SHALL cover reset mid-frame: rst_i after 2 captured pairs with ready_i=0 -> valid_o=0, FIFO empty, frame_cnt_o=0; next chirp produces a full clean frame.
